tt_bin_clock_param: RTL

Second-generation binary-coded base-60 clock core, driven by a board clock of parametrised frequency through an internal prescaler.
- Adds selectable 12/24-hour mode, a seconds field, one alarm, and edge-detected, synchronised set buttons.
- Sits under the tile top wrapper. The wrapper maps the switch/button inputs and LED outputs onto ui_in/uo_out/uio_out.

---
 rtl/tt_bin_clock_param.sv | 138 +++++++++++++
 1 files changed

// File: rtl/tt_bin_clock_param.sv
// Binary base-60 clock core: prescaled 1 s tick, h24/min/sec counters,
// 12/24-hour display, one alarm and synchronised edge-detected set buttons.
module tt_bin_clock_param #(
  parameter int unsigned TICK_DIV = 10000000,
  parameter bit          MODE_24H = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       time_set,
  input  logic       set_sel,
  input  logic       id_switch,
  input  logic       hour_id,
  input  logic       minute_id,
  input  logic       seconds_id,
  input  logic       alarm_en,
  output logic [4:0] hour_out,
  output logic [5:0] minute_out,
  output logic [5:0] seconds_out,
  output logic       pm_out,
  output logic       alarm_out,
  output logic       tick_o
);

  localparam int unsigned   PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic [5:0]    sec_q, min_q, al_min_q;
  logic [4:0]    hr_q, al_hr_q;
  logic [2:0]    sync1, sync2, prev;   // bit order {hour, minute, seconds}

  logic [5:0]    sec_n, min_n, al_min_n;
  logic [4:0]    hr_n, al_hr_n;
  logic [2:0]    rise;
  logic          freeze, tick, min_tick, alarm_hit;

  logic          show_alarm;
  logic [4:0]    disp_hr, hr12;

  function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] step24(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  assign freeze = time_set && !set_sel;
  assign tick   = !freeze && (presc == PS_LAST);
  assign rise   = sync2 & ~prev;

  // Next time/alarm values: tick carry chain, then button edits (never both on time)
  always_comb begin
    sec_n    = sec_q;
    min_n    = min_q;
    hr_n     = hr_q;
    al_min_n = al_min_q;
    al_hr_n  = al_hr_q;
    min_tick = 1'b0;
    if (tick) begin
      if (sec_q == 6'd59) begin
        sec_n    = 6'd0;
        min_tick = 1'b1;
        if (min_q == 6'd59) begin
          min_n = 6'd0;
          hr_n  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        end else begin
          min_n = min_q + 6'd1;
        end
      end else begin
        sec_n = sec_q + 6'd1;
      end
    end
    if (time_set) begin
      if (!set_sel) begin
        if (rise[0]) sec_n = step60(sec_q, id_switch);
        if (rise[1]) min_n = step60(min_q, id_switch);
        if (rise[2]) hr_n  = step24(hr_q, id_switch);
      end else begin
        if (rise[1]) al_min_n = step60(al_min_q, id_switch);
        if (rise[2]) al_hr_n  = step24(al_hr_q, id_switch);
      end
    end
  end

  // A match is only possible on a minute-changing tick, so set takes priority over that clear
  assign alarm_hit = tick && alarm_en && !time_set && (sec_n == 6'd0) &&
                     (min_n == al_min_q) && (hr_n == al_hr_q);

  // State registers: prescaler, button synchronisers, time, alarm, flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc     <= '0;
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      al_min_q  <= '0;
      al_hr_q   <= '0;
      alarm_out <= 1'b0;
      tick_o    <= 1'b0;
    end else begin
      presc    <= (freeze || presc == PS_LAST) ? '0 : presc + PW'(1);
      sync1    <= {hour_id, minute_id, seconds_id};
      sync2    <= sync1;
      prev     <= sync2;
      sec_q    <= sec_n;
      min_q    <= min_n;
      hr_q     <= hr_n;
      al_min_q <= al_min_n;
      al_hr_q  <= al_hr_n;
      tick_o   <= tick;
      if (alarm_hit)                  alarm_out <= 1'b1;
      else if (min_tick || !alarm_en) alarm_out <= 1'b0;
    end
  end

  // Display mux and 12/24-hour formatting
  always_comb begin
    show_alarm  = time_set && set_sel;
    disp_hr     = show_alarm ? al_hr_q  : hr_q;
    minute_out  = show_alarm ? al_min_q : min_q;
    seconds_out = show_alarm ? 6'd0     : sec_q;
    hr12        = (disp_hr >= 5'd12) ? disp_hr - 5'd12 : disp_hr;
    if (MODE_24H) begin
      hour_out = disp_hr;
      pm_out   = 1'b0;
    end else begin
      hour_out = (hr12 == 5'd0) ? 5'd12 : hr12;
      pm_out   = (disp_hr >= 5'd12);
    end
  end

endmodule
